mod_reduce_seq: RTL and testbench
=================================

# mod_reduce_seq

Sequential modular-reduction stage that sits directly downstream of the 128-bit pipelined squarer. It consumes the 256-bit square and its one-cycle done pulse, and produces `x mod m` for a 128-bit modulus. It uses a restoring shift/conditional-subtract loop that consumes one dividend bit per cycle. It is the reduction half of the squaring step in the modular-exponentiation datapath.

## Interface
- `IN_W`, default 256: dividend width, equal to the squarer output width.
- `MOD_W`, default 128: modulus and remainder width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request, driven from the squarer `done`.
- `x`  in  IN_W: dividend, driven from the squarer `square`; sampled only on an accepted start.
- `m`  in  MOD_W: modulus; sampled only on an accepted start.
- `r`  out  MOD_W: remainder; holds its value until the next completion.
- `done`  out  1: one-cycle pulse, valid together with `r` and `err`.
- `err`  out  1: set with `done` when `m == 0`.
- `busy`  out  1: high while a reduction is in progress.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 and `m`≠0: latch `x` into shift reg `xs` and `m` into `ms`, set `rem`=0 and `cnt`=IN_W-1, go to RUN, `busy`<=1.
  - `start`=1 and `m`=0: go to FIN with err flag set; no iteration.
- RUN, one step per cycle:
  - `t = {rem[MOD_W-1:0], xs[IN_W-1]}` (MOD_W+1 bits); `xs <<= 1`.
  - `rem <= (t >= {1'b0,ms}) ? t - ms : t`.
  - The compare/subtract is MOD_W+1 bits wide; the invariant `rem < ms` guarantees `t < 2·ms`, so one subtract is sufficient.
  - `cnt==0`: go to FIN; else `cnt--`.
- FIN: `r <= rem[MOD_W-1:0]` (0 if err), `err <=` flag, `done <= 1`, `busy <= 0`, go to IDLE.
- `start` while not in IDLE (including the FIN cycle) is ignored and not queued. Upstream must space requests at least IN_W+2 cycles apart.
- `done` and `err` are deasserted on the cycle after the pulse. `r` is held.
- Reset (any state, asynchronous):
  - State returns to IDLE.
  - `r`=0, `done`=0, `err`=0, `busy`=0; internal regs are cleared.
  - An in-flight result is discarded and no `done` is produced.

## Timing
- Start accepted at edge E0.
- RUN iterations occur at edges E1..E_IN_W; the FIN update occurs at edge E_(IN_W+1).
- `done`/`r` are visible for the cycle after E_(IN_W+1): latency IN_W+1 cycles (257 at default).
- The `m`=0 path: `done`+`err` after E1, latency 1 cycle.
- `busy` is high from after E0 through E_(IN_W+1), where it falls on the same edge `done` rises.
- A new `start` is accepted at the earliest in the cycle `done` is high (state IDLE). Back-to-back throughput is one result per IN_W+2 cycles.

## Structure
- The shared package holds:
  - default widths (`SQ_IN_W`=256, `SQ_MOD_W`=128);
  - FSM state encoding as localparams (IDLE=2'd0, RUN=2'd1, FIN=2'd2);
  - the counter width `$clog2(IN_W)`.
- One natural combinational sub-module: `mod_cond_sub`, which takes `t` and `ms` and returns the reduced `rem` as a MOD_W+1-bit compare-and-subtract. It can be reused later by the multiply-reduce stage.
- Top-level integration: squarer `square`→`x`, squarer `done`→`start`.

## Test plan
- Basic reduction: reset, then `x`=9, `m`=5, `start` pulse → `done` exactly 257 cycles later with `r`=4, `err`=0; `busy` high for the whole interval.
- Squarer-chained values:
  - `x`=152399025 (12345²), `m`=1000 → `r`=25.
  - `x`=7, `m`=100 → `r`=7.
- Extremes:
  - `x`=2^256-1, `m`=2^128-1 → `r`=0.
  - `x`=2^256-1, `m`=1 → `r`=0.
  - `x`=2^255, `m`=3 → `r`=2.
- Zero modulus: `m`=0, `x`=9 → `done`+`err` one cycle after start, `r`=0, no RUN cycles.
- Busy rejection: second `start` with different `x` at cycle 100 of a run → ignored; first result is unchanged and only one `done` is produced. A `start` issued during the `done` cycle is accepted.
- Reset mid-run: deassert `rst_n` at cycle 50 of a run → all outputs are 0 immediately and no `done` follows. A fresh `x`=9, `m`=5 run then yields `r`=4.

Source files
------------

// File: rtl/mod_reduce_seq_pkg.sv
// mod_reduce_seq_pkg: shared widths and FSM encoding for the modular-reduction stage.
package mod_reduce_seq_pkg;
    localparam int SQ_IN_W  = 256;
    localparam int SQ_MOD_W = 128;
    localparam int SQ_CNT_W = $clog2(SQ_IN_W);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;
endpackage

// File: rtl/mod_reduce_seq_if.sv
// mod_reduce_seq_if: request/result bundle between the squarer side and the reduction stage.
interface mod_reduce_seq_if
    import mod_reduce_seq_pkg::*;
#(
    parameter int IN_W  = SQ_IN_W,
    parameter int MOD_W = SQ_MOD_W
);
    logic             start;
    logic [IN_W-1:0]  x;
    logic [MOD_W-1:0] m;
    logic [MOD_W-1:0] r;
    logic             done;
    logic             err;
    logic             busy;
    modport master (output start, x, m, input r, done, err, busy);
    modport slave  (input start, x, m, output r, done, err, busy);
endinterface

// File: rtl/mod_reduce_seq_cond_sub.sv
// mod_cond_sub: one restoring-division step, subtract ms from t when t >= ms.
module mod_cond_sub
    import mod_reduce_seq_pkg::*;
#(
    parameter int MOD_W = SQ_MOD_W
) (
    input  logic [MOD_W:0]   t_i,
    input  logic [MOD_W-1:0] ms_i,
    output logic [MOD_W-1:0] rem_o
);
    logic [MOD_W:0] ms_ext;
    assign ms_ext = {1'b0, ms_i};
    // t < 2*ms keeps the difference below ms, so it always fits in MOD_W bits
    assign rem_o = (t_i >= ms_ext) ? MOD_W'(t_i - ms_ext) : t_i[MOD_W-1:0];
endmodule

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: x mod m by shift/conditional-subtract, one dividend bit per cycle.
module mod_reduce_seq
    import mod_reduce_seq_pkg::*;
#(
    parameter int IN_W  = SQ_IN_W,
    parameter int MOD_W = SQ_MOD_W
) (
    input logic            clk,
    input logic            rst_n,
    mod_reduce_seq_if.slave bus
);
    localparam int CNT_W = $clog2(IN_W);
    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  xs_q, xs_d;
    logic [MOD_W-1:0] ms_q, ms_d, rem_q, rem_d, r_q, r_d, sub_rem;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
    mod_cond_sub #(.MOD_W(MOD_W)) u_sub (
        .t_i  ({rem_q, xs_q[IN_W-1]}),
        .ms_i (ms_q),
        .rem_o(sub_rem)
    );
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ms_d    = ms_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        r_d     = r_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                xs_d    = bus.x;
                ms_d    = bus.m;
                rem_d   = '0;
                cnt_d   = CNT_W'(IN_W - 1);
                flag_d  = (bus.m == '0);
                busy_d  = 1'b1;
                state_d = (bus.m == '0) ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                xs_d    = {xs_q[IN_W-2:0], 1'b0};
                rem_d   = sub_rem;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? ST_FIN : ST_RUN;
            end
            ST_FIN: begin
                r_d     = flag_q ? '0 : rem_q;
                err_d   = flag_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            xs_q    <= '0;
            ms_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ms_q    <= ms_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.r    = r_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb_mod_reduce_seq: scoreboard bench, x mod m reference model vs the reduction stage.
module tb_mod_reduce_seq;
    import mod_reduce_seq_pkg::*;
    localparam int IN_W  = SQ_IN_W;
    localparam int MOD_W = SQ_MOD_W;
    typedef struct {
        logic [MOD_W-1:0] r;
        logic             err;
        int               acc;
        int               due;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    mod_reduce_seq_if #(.IN_W(IN_W), .MOD_W(MOD_W)) bus ();
    mod_reduce_seq #(.IN_W(IN_W), .MOD_W(MOD_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: busy window and every done pulse are compared against the scoreboard
    always @(negedge clk) begin
        logic bexp;
        exp_t e;
        if (rst_n) begin
            bexp = (sb.size() > 0) && (cyc > sb[0].acc) && (cyc < sb[0].due);
            checks++;
            if (bus.busy !== bexp) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, bexp);
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d r=%h err=%b", cyc, bus.r, bus.err);
                end else begin
                    e = sb.pop_front();
                    if (bus.r !== e.r || bus.err !== e.err || cyc != e.due) begin
                        errors++;
                        $display("FAIL result cyc=%0d got r=%h err=%b exp r=%h err=%b at cyc=%0d",
                                 cyc, bus.r, bus.err, e.r, e.err, e.due);
                    end
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_done cyc=%0d exp r=%h", cyc, sb[0].r);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [IN_W-1:0] x, input logic [MOD_W-1:0] m, input bit accept);
        exp_t e;
        bus.start = 1'b1;
        bus.x     = x;
        bus.m     = m;
        if (accept) begin
            e.r   = (m == '0) ? '0 : MOD_W'(x % m);
            e.err = (m == '0);
            e.acc = cyc;
            e.due = cyc + 1 + ((m == '0) ? 1 : IN_W + 1);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = {8{$urandom}};
        bus.m     = {4{$urandom}};
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cyc=%0d got=%b exp=1", cyc, bus.done);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus.r, bus.done, bus.err, bus.busy} !== '0) begin
            errors++;
            $display("FAIL %s got r=%h done=%b err=%b busy=%b exp all 0",
                     name, bus.r, bus.done, bus.err, bus.busy);
        end
    endtask

    logic [IN_W-1:0]  dx[6] = '{256'd152399025, 256'd7, '1, '1, {1'b1, 255'b0}, 256'd9};
    logic [MOD_W-1:0] dm[6] = '{128'd1000, 128'd100, '1, 128'd1, 128'd3, 128'd0};

    initial begin
        logic [IN_W-1:0]  rx;
        logic [MOD_W-1:0] rm;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.m     = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        issue(256'd9, 128'd5, 1'b1);
        wait_done();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(dx[i], dm[i], 1'b1);
            wait_done();
        end
        // a start mid-run is dropped; a start in the done cycle is taken
        @(negedge clk);
        issue({8{32'hdeadbeef}}, 128'd12345, 1'b1);
        repeat (98) @(negedge clk);
        issue(256'd77, 128'd12345, 1'b0);
        wait_done();
        issue(256'd9, 128'd5, 1'b1);
        wait_done();
        @(negedge clk);
        issue({8{32'h13579bdf}}, 128'd99991, 1'b1);
        repeat (48) @(negedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        issue(256'd9, 128'd5, 1'b1);
        wait_done();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) rx[k*32+:32] = $urandom;
            for (int k = 0; k < 4; k++) rm[k*32+:32] = $urandom;
            case ($urandom_range(0, 3))
                0: rm = 128'($urandom_range(1, 1000));
                1: rm = (i == 5) ? '0 : rm >> $urandom_range(0, 120);
                default: ;
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(rx, rm, 1'b1);
            wait_done();
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
